// File: rtl/serial_adder_decoder_pkg.sv
// Shared FSM state encoding for the bit-serial adder.
package serial_adder_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_decoder_fa.sv
// Full-adder cell built from a 3-to-8 minterm decoder followed by OR gates.
module full_adder_3x8_decoder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic [7:0] minterm;

    // One-hot minterm index is {a, b, cin}
    always_comb begin
        minterm = 8'd0;
        minterm[{a, b, cin}] = 1'b1;
    end

    assign sum   = minterm[1] | minterm[2] | minterm[4] | minterm[7];
    assign carry = minterm[3] | minterm[5] | minterm[6] | minterm[7];

endmodule

// File: rtl/serial_adder_decoder.sv
// Bit-serial LSB-first adder with valid/ready handshakes on both sides.
module serial_adder_decoder
    import serial_adder_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;
    logic               fa_sum;
    logic               fa_carry;

    full_adder_3x8_decoder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake/status outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            busy      <= (state_next == RUN);
            out_valid <= (state_next == DONE);
        end
    end

    // Result lands in sum/cout only on the final bit, so they hold the last result otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    sum_sh  <= {fa_sum, sum_sh[WIDTH-1:1]};
                    carry_q <= fa_carry;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum  <= {fa_sum, sum_sh[WIDTH-1:1]};
                        cout <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_decoder.sv
// Self-checking bench for serial_adder_decoder (WIDTH=8) against an arithmetic model.
module tb_serial_adder_decoder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    logic fa_a, fa_b, fa_cin, fa_sum, fa_carry;

    int checks = 0;
    int errors = 0;

    serial_adder_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    full_adder_3x8_decoder u_cell (
        .a     (fa_a),
        .b     (fa_b),
        .cin   (fa_cin),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; meddle drives junk requests while the block is busy
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_c, input int stall, input bit meddle);
        logic [W:0] exp;
        int n;
        exp = (W+1)'(op_a) + (W+1)'(op_b) + (W+1)'(op_c);
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a = op_a;
        b = op_b;
        cin = op_c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_in_run", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            if (meddle && n >= 2) begin
                in_valid = 1'b1;
                a = '0;
                b = '0;
            end
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(W));
        check("sum", 32'(sum), 32'(exp[W-1:0]));
        check("cout", 32'(cout), 32'(exp[W]));
        check("busy_in_done", 32'(busy), 32'd0);
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            tick();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(sum), 32'(exp[W-1:0]));
            check("stall_cout", 32'(cout), 32'(exp[W]));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
        check("idle_sum_hold", 32'(sum), 32'(exp[W-1:0]));
        check("idle_cout_hold", 32'(cout), 32'(exp[W]));
        if (meddle) begin
            tick();
            check("meddle_not_accepted", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        fa_a = 1'b0;
        fa_b = 1'b0;
        fa_cin = 1'b0;

        // Exhaustive full-adder cell truth table
        for (int i = 0; i < 8; i++) begin
            fa_a = 1'(i >> 2);
            fa_b = 1'(i >> 1);
            fa_cin = 1'(i);
            #1;
            check("cell", {30'd0, fa_carry, fa_sum},
                  32'(fa_a) + 32'(fa_b) + 32'(fa_cin));
        end

        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);

        run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        run_op(8'hA5, 8'h11, 1'b1, 5, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 1, 1'b1);

        // Reset on the 4th RUN edge aborts the operation
        a = 8'h77;
        b = 8'h88;
        cin = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_out_valid", 32'(seen), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
